pim_inst_sequencer: RTL and testbench

- Command front-end of the SRAM PIM macro: accepts one instruction at a time over a valid/ready handshake.
- Decodes opcode, address mode and op width, then steps the macro through its work modes (pre-work, read/execute, write-back), driving CD/NWR/NRD, the row address, the ALU opcode/immediate and the output-mux select each cycle.
- Sits directly upstream of the SRAM PIM array/ALU datapath; uses the package opcode, addrmode, opwidth, omux and work-mode encodings.

---
 rtl/pim_inst_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pim_inst_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_inst_sequencer.sv
// pim_inst_sequencer
//   Command front-end of the SRAM PIM macro. Accepts one instruction at a
//   time over a valid/ready handshake, decodes it, and steps the macro
//   through its work modes (pre-work, read/execute, write-back). Every
//   control output comes straight from a flop.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready        instruction handshake (ready only in IDLE)
//   in_pim, in_write           PIM/ALU op vs. normal access; read/write
//   in_opcode, in_addrmode,
//   in_opwidth, in_imm         ALU op fields
//   in_row_a/b/d               source rows A/B, destination row
//   sram_cd/nwr/nrd/row        SRAM macro control and row address
//   alu_opcode/imm/opwidth     registered ALU fields
//   omux_sel                   output-mux select during write-back
//   work_mode                  work-mode index of the current cycle
//   done                       pulse on the last cycle of an instruction
//   illegal                    pulse when a PIM opcode of 0 is rejected
//
// Optional build macro
//   PIM_SEQ_PERF_CNT_EN        adds perf_pim_ops / perf_busy_cycles counters
module pim_inst_sequencer #(
  parameter int ROW_ADDR_BIT = 8,
  parameter int ALU_IMM_BIT  = 6,
  parameter int EXEC_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_pim,
  input  logic                    in_write,
  input  logic [3:0]              in_opcode,
  input  logic [1:0]              in_addrmode,
  input  logic [1:0]              in_opwidth,
  input  logic [ALU_IMM_BIT-1:0]  in_imm,
  input  logic [ROW_ADDR_BIT-1:0] in_row_a,
  input  logic [ROW_ADDR_BIT-1:0] in_row_b,
  input  logic [ROW_ADDR_BIT-1:0] in_row_d,
  output logic                    sram_cd,
  output logic                    sram_nwr,
  output logic                    sram_nrd,
  output logic [ROW_ADDR_BIT-1:0] sram_row,
  output logic [3:0]              alu_opcode,
  output logic [ALU_IMM_BIT-1:0]  alu_imm,
  output logic [1:0]              alu_opwidth,
  output logic [1:0]              omux_sel,
  output logic [3:0]              work_mode,
  output logic                    done,
  output logic                    illegal
`ifdef PIM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_pim_ops,
  output logic [31:0]             perf_busy_cycles
`endif
);

  // Work-mode indices
  localparam logic [3:0] WM_NR = 4'd0;
  localparam logic [3:0] WM_NW = 4'd1;
  localparam logic [3:0] WM_PR = 4'd2;
  localparam logic [3:0] WM_PW_BASE = 4'd3;  // PWRSS..PWSRR = 3..6
  localparam logic [3:0] WM_NP = 4'd7;
  localparam logic [3:0] WM_PP_BASE = 4'd8;  // PPRSS..PPSRR = 8..11

  // Address modes and output-mux selects
  localparam logic [1:0] ADDR_RRR  = 2'd2;
  localparam logic [1:0] ADDR_SRR  = 2'd3;
  localparam logic [1:0] OMUX_NONE = 2'd0;
  localparam logic [1:0] OMUX_SRAM = 2'd1;
  localparam logic [1:0] OMUX_R2   = 2'd2;
  localparam logic [1:0] OMUX_R3   = 2'd3;

  localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_NRD, S_NWR, S_EXEC, S_WB
  } state_e;

  state_e state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;

  // Captured instruction fields
  logic                    pim_reg, write_reg;
  logic [1:0]              addrmode_reg;
  logic [3:0]              opcode_reg;
  logic [1:0]              opwidth_reg;
  logic [ALU_IMM_BIT-1:0]  imm_reg;
  logic [ROW_ADDR_BIT-1:0] row_a_reg, row_b_reg, row_d_reg;

  // Registered outputs and their next values
  logic                    ready_reg, ready_next;
  logic                    cd_reg, cd_next;
  logic                    nwr_reg, nwr_next;
  logic                    nrd_reg, nrd_next;
  logic [ROW_ADDR_BIT-1:0] row_reg, row_next;
  logic [1:0]              omux_reg, omux_next;
  logic [3:0]              mode_reg, mode_next;
  logic                    done_reg, done_next;
  logic                    illegal_reg, illegal_next;

  logic accept, bad_op;
  logic pim_c;
  logic [1:0] am_c;

  assign accept = in_valid & ready_reg;
  assign bad_op = in_pim & (in_opcode == 4'd0);

  // PRE is entered straight from the accept cycle, so its decode must look
  // at the incoming fields rather than the (not yet loaded) capture regs.
  assign pim_c = accept ? in_pim : pim_reg;
  assign am_c  = accept ? in_addrmode : addrmode_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    illegal_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept && !bad_op) state_next = S_PRE;
        illegal_next = accept & bad_op;
      end
      S_PRE: begin
        cnt_next = 2'd0;
        if (pim_reg)        state_next = S_EXEC;
        else if (write_reg) state_next = S_NWR;
        else                state_next = S_NRD;
      end
      S_EXEC: begin
        if (cnt_reg == EXEC_LAST) state_next = S_WB;
        else                      cnt_next = cnt_reg + 2'd1;
      end
      default: state_next = S_IDLE;  // NRD, NWR, WB
    endcase
  end

  // Output decode of the state being entered, registered below.
  always_comb begin
    ready_next = 1'b0;
    cd_next    = 1'b0;
    nwr_next   = 1'b1;
    nrd_next   = 1'b0;
    row_next   = row_reg;
    omux_next  = OMUX_NONE;
    mode_next  = WM_NR;
    done_next  = 1'b0;
    case (state_next)
      S_IDLE: ready_next = 1'b1;
      S_PRE: begin
        cd_next   = pim_c;
        nrd_next  = 1'b1;
        mode_next = pim_c ? (WM_PP_BASE + {2'b00, am_c}) : WM_NP;
      end
      S_NRD: begin
        row_next  = row_a_reg;
        done_next = 1'b1;
      end
      S_NWR: begin
        nwr_next  = 1'b0;
        mode_next = WM_NW;
        row_next  = row_a_reg;
        done_next = 1'b1;
      end
      S_EXEC: begin
        cd_next   = 1'b1;
        mode_next = WM_PR;
        // First operand read fetches row A, every later one row B.
        row_next  = (state_reg == S_PRE) ? row_a_reg : row_b_reg;
      end
      S_WB: begin
        cd_next   = 1'b1;
        nwr_next  = 1'b0;
        mode_next = WM_PW_BASE + {2'b00, addrmode_reg};
        row_next  = row_d_reg;
        done_next = 1'b1;
        if (addrmode_reg == ADDR_SRR)      omux_next = OMUX_SRAM;
        else if (addrmode_reg == ADDR_RRR) omux_next = OMUX_R3;
        else                               omux_next = OMUX_R2;
      end
      default: ready_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 2'd0;
      pim_reg      <= 1'b0;
      write_reg    <= 1'b0;
      addrmode_reg <= 2'd0;
      opcode_reg   <= 4'd0;
      opwidth_reg  <= 2'd0;
      imm_reg      <= '0;
      row_a_reg    <= '0;
      row_b_reg    <= '0;
      row_d_reg    <= '0;
      ready_reg    <= 1'b1;
      cd_reg       <= 1'b0;
      nwr_reg      <= 1'b1;
      nrd_reg      <= 1'b0;
      row_reg      <= '0;
      omux_reg     <= OMUX_NONE;
      mode_reg     <= WM_NR;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ready_reg   <= ready_next;
      cd_reg      <= cd_next;
      nwr_reg     <= nwr_next;
      nrd_reg     <= nrd_next;
      row_reg     <= row_next;
      omux_reg    <= omux_next;
      mode_reg    <= mode_next;
      done_reg    <= done_next;
      illegal_reg <= illegal_next;
      if (accept) begin
        pim_reg      <= in_pim;
        write_reg    <= in_write;
        addrmode_reg <= in_addrmode;
        opcode_reg   <= in_opcode;
        opwidth_reg  <= in_opwidth;
        imm_reg      <= in_imm;
        row_a_reg    <= in_row_a;
        row_b_reg    <= in_row_b;
        row_d_reg    <= in_row_d;
      end
    end
  end

  assign in_ready    = ready_reg;
  assign sram_cd     = cd_reg;
  assign sram_nwr    = nwr_reg;
  assign sram_nrd    = nrd_reg;
  assign sram_row    = row_reg;
  assign alu_opcode  = opcode_reg;
  assign alu_imm     = imm_reg;
  assign alu_opwidth = opwidth_reg;
  assign omux_sel    = omux_reg;
  assign work_mode   = mode_reg;
  assign done        = done_reg;
  assign illegal     = illegal_reg;

`ifdef PIM_SEQ_PERF_CNT_EN
  logic [31:0] pim_ops_reg, busy_cycles_reg;

  // Free-running, wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pim_ops_reg     <= 32'd0;
      busy_cycles_reg <= 32'd0;
    end else begin
      if (state_reg == S_WB) pim_ops_reg <= pim_ops_reg + 32'd1;
      if (!ready_reg)        busy_cycles_reg <= busy_cycles_reg + 32'd1;
    end
  end

  assign perf_pim_ops     = pim_ops_reg;
  assign perf_busy_cycles = busy_cycles_reg;
`endif

endmodule

// File: tb/tb_pim_inst_sequencer.sv
// Self-checking bench for pim_inst_sequencer. Each scenario task pushes the
// expected per-cycle output record onto a scoreboard queue when it drives an
// instruction, then pops and compares one record per clock.
module tb_pim_inst_sequencer;
  localparam int RB = 8;
  localparam int IB = 6;
  localparam int EC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_pim = 1'b0;
  logic          in_write = 1'b0;
  logic [3:0]    in_opcode = 4'd0;
  logic [1:0]    in_addrmode = 2'd0;
  logic [1:0]    in_opwidth = 2'd0;
  logic [IB-1:0] in_imm = '0;
  logic [RB-1:0] in_row_a = '0, in_row_b = '0, in_row_d = '0;
  logic          sram_cd, sram_nwr, sram_nrd;
  logic [RB-1:0] sram_row;
  logic [3:0]    alu_opcode;
  logic [IB-1:0] alu_imm;
  logic [1:0]    alu_opwidth;
  logic [1:0]    omux_sel;
  logic [3:0]    work_mode;
  logic          done, illegal;
`ifdef PIM_SEQ_PERF_CNT_EN
  logic [31:0]   perf_pim_ops, perf_busy_cycles;
`endif

  pim_inst_sequencer #(.ROW_ADDR_BIT(RB), .ALU_IMM_BIT(IB), .EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pim(in_pim), .in_write(in_write), .in_opcode(in_opcode),
    .in_addrmode(in_addrmode), .in_opwidth(in_opwidth), .in_imm(in_imm),
    .in_row_a(in_row_a), .in_row_b(in_row_b), .in_row_d(in_row_d),
    .sram_cd(sram_cd), .sram_nwr(sram_nwr), .sram_nrd(sram_nrd),
    .sram_row(sram_row), .alu_opcode(alu_opcode), .alu_imm(alu_imm),
    .alu_opwidth(alu_opwidth), .omux_sel(omux_sel), .work_mode(work_mode),
    .done(done), .illegal(illegal)
`ifdef PIM_SEQ_PERF_CNT_EN
    , .perf_pim_ops(perf_pim_ops), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic          cd;
    logic          nwr;
    logic          nrd;
    logic [RB-1:0] row;
    logic [3:0]    mode;
    logic [1:0]    omux;
    logic          done;
    logic          ill;
    logic [3:0]    opc;
    logic [IB-1:0] imm;
    logic [1:0]    ow;
  } rec_t;

  rec_t sb[$];
  rec_t obs, exp_r;
  int n_vec = 0;
  int n_err = 0;

  // Model state: row and ALU registers hold between instructions.
  logic [RB-1:0] exp_row = '0;
  logic [3:0]    exp_opc = 4'd0;
  logic [IB-1:0] exp_imm = '0;
  logic [1:0]    exp_ow  = 2'd0;

  assign obs = {in_ready, sram_cd, sram_nwr, sram_nrd, sram_row, work_mode,
                omux_sel, done, illegal, alu_opcode, alu_imm, alu_opwidth};

  function automatic rec_t mk(logic rdy, logic cd, logic nwr, logic nrd,
                              logic [RB-1:0] row, logic [3:0] mode,
                              logic [1:0] omux, logic dn, logic il);
    return {rdy, cd, nwr, nrd, row, mode, omux, dn, il, exp_opc, exp_imm, exp_ow};
  endfunction

  function automatic rec_t idle_rec();
    return mk(1'b1, 1'b0, 1'b1, 1'b0, exp_row, 4'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf("rdy=%b cd=%b nwr=%b nrd=%b row=%h mode=%0d omux=%0d done=%b ill=%b opc=%h imm=%h ow=%0d",
                     r.ready, r.cd, r.nwr, r.nrd, r.row, r.mode, r.omux,
                     r.done, r.ill, r.opc, r.imm, r.ow);
  endfunction

  task automatic set_inputs(logic pim, logic wr, logic [3:0] opc, logic [1:0] am,
                            logic [IB-1:0] imm, logic [1:0] ow,
                            logic [RB-1:0] a, logic [RB-1:0] b, logic [RB-1:0] d);
    in_valid = 1'b1; in_pim = pim; in_write = wr; in_opcode = opc;
    in_addrmode = am; in_imm = imm; in_opwidth = ow;
    in_row_a = a; in_row_b = b; in_row_d = d;
    exp_opc = opc; exp_imm = imm; exp_ow = ow;
  endtask

  task automatic test_reset();
    int cyc = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs !== idle_rec()) begin
      n_err++;
      $display("FAIL reset_hold: got %s want %s", fmt(obs), fmt(idle_rec()));
    end
    rst_n = 1'b1;
    repeat (5) sb.push_back(idle_rec());
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got %s want %s", cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    $display("txn reset: idle outputs checked for %0d cycles", cyc);
  endtask

  // Normal SRAM access; called at a negedge, returns at the negedge of the
  // trailing IDLE cycle.
  task automatic test_normal(string lbl, logic wr, logic [3:0] opc, logic [RB-1:0] a);
    int cyc = 0;
    set_inputs(1'b0, wr, opc, 2'd0, 6'h15, 2'd1, a, 8'h00, 8'h00);
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, exp_row, 4'd7, 2'd0, 1'b0, 1'b0));
    exp_row = a;
    sb.push_back(mk(1'b0, 1'b0, !wr, 1'b0, a, wr ? 4'd1 : 4'd0, 2'd0, 1'b1, 1'b0));
    sb.push_back(idle_rec());
    while (sb.size() > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL %s c%0d: got %s want %s", lbl, cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    $display("txn %s: %s row=%h, %0d cycles checked", lbl, wr ? "write" : "read", a, cyc);
  endtask

  task automatic test_pim(string lbl, logic [3:0] opc, logic [1:0] am, logic [IB-1:0] imm,
                          logic [1:0] ow, logic [RB-1:0] a, logic [RB-1:0] b, logic [RB-1:0] d);
    int cyc = 0;
    logic [1:0] om;
    set_inputs(1'b1, 1'b0, opc, am, imm, ow, a, b, d);
    sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, exp_row, 4'd8 + {2'b00, am}, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < EC; i++) begin
      exp_row = (i == 0) ? a : b;
      sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, exp_row, 4'd2, 2'd0, 1'b0, 1'b0));
    end
    om = (am == 2'd3) ? 2'd1 : (am == 2'd2) ? 2'd3 : 2'd2;
    exp_row = d;
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, d, 4'd3 + {2'b00, am}, om, 1'b1, 1'b0));
    sb.push_back(idle_rec());
    while (sb.size() > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL %s c%0d: got %s want %s", lbl, cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    $display("txn %s: pim op=%h am=%0d a=%h b=%h d=%h, %0d cycles checked",
             lbl, opc, am, a, b, d, cyc);
  endtask

  task automatic test_illegal();
    int cyc = 0;
    set_inputs(1'b1, 1'b0, 4'd0, 2'd2, 6'h2A, 2'd3, 8'h77, 8'h78, 8'h79);
    sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, exp_row, 4'd0, 2'd0, 1'b0, 1'b1));
    sb.push_back(idle_rec());
    sb.push_back(idle_rec());
    while (sb.size() > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL illegal c%0d: got %s want %s", cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    $display("txn illegal: pim opcode 0 rejected, %0d cycles checked", cyc);
  endtask

  task automatic test_back_to_back();
    // Each call ends on the IDLE cycle and the next drives immediately, so
    // exactly one IDLE cycle separates the instructions.
    test_normal("b2b_wr", 1'b1, 4'h6, 8'hA5);
    test_pim("b2b_rsr", 4'h3, 2'd1, 6'h01, 2'd2, 8'h10, 8'h20, 8'h30);
    test_normal("b2b_rd", 1'b0, 4'h0, 8'h5A);
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    set_inputs(1'b1, 1'b0, 4'h4, 2'd0, 6'h0F, 2'd1, 8'h11, 8'h22, 8'h33);
    sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, exp_row, 4'd8, 2'd0, 1'b0, 1'b0));
    sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 4'd2, 2'd0, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL midrst c%0d: got %s want %s", cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    @(posedge clk);   // second EXEC cycle begins
    #2 rst_n = 1'b0;
    exp_row = '0; exp_opc = 4'd0; exp_imm = '0; exp_ow = 2'd0;
    #1;
    n_vec++;
    if (obs !== idle_rec()) begin
      n_err++;
      $display("FAIL midrst_async: got %s want %s", fmt(obs), fmt(idle_rec()));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) sb.push_back(idle_rec());
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_r = sb.pop_front();
      n_vec++;
      if (obs !== exp_r) begin
        n_err++;
        $display("FAIL midrst_after c%0d: got %s want %s", cyc, fmt(obs), fmt(exp_r));
      end
      cyc++;
    end
    $display("txn midrst: instruction abandoned in EXEC, %0d cycles checked", cyc);
    test_pim("post_rst", 4'h1, 2'd2, 6'h05, 2'd0, 8'h01, 8'h02, 8'h05);
  endtask

  initial begin
    test_reset();
    test_normal("rd_3c", 1'b0, 4'h0, 8'h3C);
    test_normal("wr_c3", 1'b1, 4'h9, 8'hC3);
    test_pim("add_rrr", 4'h1, 2'd2, 6'h07, 2'd1, 8'h01, 8'h02, 8'h05);
    test_pim("srr_ff", 4'hB, 2'd3, 6'h3F, 2'd3, 8'h40, 8'h41, 8'hFF);
    test_pim("rss", 4'h2, 2'd0, 6'h12, 2'd2, 8'h80, 8'h81, 8'h82);
    test_illegal();
    test_normal("rd_after_ill", 1'b0, 4'h0, 8'h00);
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
